coin_collector: RTL and testbench
=================================

COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: idle cycles before auto-refund in COLLECT, and response-wait limit in WAIT.
REQ-002 The block SHALL have parameter CREDIT_MAX, default 15: credit ceiling, fixed by the 4-bit money path.
REQ-003 The block SHALL have ports:
  clk  in  1  single clock; all logic on rising edge
  reset  in  1  synchronous, active-high
  coin_valid  in  1  one-cycle coin strobe
  coin_value  in  2  00 invalid, 01 = 1, 10 = 2, 11 = 5
  cancel  in  1  refund request
  buy  in  1  purchase request, sampled with sel_type/sel_number
  sel_type  in  3  product type, legal 1..5
  sel_number  in  4  quantity, legal 1..15
  money  out  4  credit presented to the purchase stage
  index_type  out  3  latched sel_type
  in_number  out  4  latched sel_number
  req_valid  out  1  one-cycle purchase request to the purchase stage
  rsp_valid  in  1  one-cycle result strobe from the purchase stage
  rsp_error  in  1  purchase refused
  rsp_remaining  in  4  credit left after purchase
  change  out  4  refund amount, valid with change_valid
  change_valid  out  1  one-cycle refund strobe
  coin_reject  out  1  one-cycle pulse: coin returned unaccepted
  busy  out  1  high in REQUEST, WAIT and REFUND

Function
REQ-004 The FSM SHALL have states IDLE, COLLECT, REQUEST, WAIT, REFUND.
REQ-005 IDLE: credit = 0; an accepted coin SHALL load credit and move to COLLECT the next cycle.
REQ-006 A coin SHALL be accepted only in IDLE/COLLECT, with coin_value != 00, and when credit + value <= CREDIT_MAX.
REQ-007 A coin not accepted SHALL leave credit unchanged and pulse coin_reject the following cycle.
REQ-008 The credit sum SHALL be computed 5 bits wide and compared before truncation; credit SHALL never wrap.
REQ-009 COLLECT: the timer SHALL clear on each accepted coin. When it reaches TIMEOUT_CYCLES-1 without an accepted coin, the FSM SHALL go to REFUND.
REQ-010 COLLECT: buy with legal sel_type and sel_number SHALL latch index_type/in_number and go to REQUEST.
REQ-011 An illegal buy SHALL be ignored, and the timer SHALL be left unchanged.
REQ-012 Same-cycle priority in COLLECT SHALL be: cancel > buy > coin. The losing coin SHALL be rejected per REQ-007.
REQ-013 COLLECT: cancel SHALL go to REFUND.
REQ-014 REQUEST: req_valid SHALL be high exactly one cycle, with money = credit. The next state SHALL be WAIT, with the timer cleared.
REQ-015 WAIT, on rsp_valid with rsp_error = 1: credit SHALL be unchanged and the next state SHALL be COLLECT.
REQ-016 WAIT, on rsp_valid with rsp_error = 0: credit SHALL be set to rsp_remaining. The next state SHALL be REFUND if rsp_remaining > 0, else IDLE.
REQ-017 WAIT: cancel SHALL be ignored; coins SHALL be rejected.
REQ-018 WAIT: if no rsp_valid arrives within TIMEOUT_CYCLES, the FSM SHALL go to REFUND with credit unchanged.
REQ-019 REFUND: change = credit and change_valid SHALL be high for one cycle. Credit SHALL be cleared and the next state SHALL be IDLE.
REQ-020 rsp_valid outside WAIT SHALL be ignored.
REQ-021 money SHALL equal credit in every state. index_type/in_number SHALL hold until the next legal buy.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On reset: state = IDLE; credit, timer, money, index_type, in_number and change = 0; req_valid, change_valid, coin_reject and busy = 0.
REQ-024 Reset mid-transaction SHALL discard credit without issuing change_valid.

Structure
REQ-025 Package vm_pkg SHALL hold the coin encodings, coin value constants (1/2/5), the state enum, CREDIT_MAX and the legal type range 1..5.
REQ-026 Sub-module vm_timer SHALL implement the clearable TIMEOUT_CYCLES counter with a terminal-count output.

Verification
REQ-027 The bench SHALL cover: coins 5, 5, 2 -> money = 12; then coin 5 -> coin_reject pulse, money stays 12.
REQ-028 The bench SHALL cover: credit 10, buy type 3 qty 2 -> one req_valid pulse; rsp ok with remaining 4 -> change = 4 with change_valid, then IDLE.
REQ-029 The bench SHALL cover: credit 6, buy -> rsp_error -> back in COLLECT with money = 6; then cancel -> change = 6.
REQ-030 The bench SHALL cover: credit 3, no activity for TIMEOUT_CYCLES -> change = 3, IDLE.
REQ-031 The bench SHALL cover: same cycle cancel + buy + coin in COLLECT with credit 7 -> REFUND with change = 7, coin_reject, no req_valid.
REQ-032 The bench SHALL cover: reset asserted in WAIT with credit 9 -> all outputs 0, no change_valid.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the coin collector: coin encodings and values, FSM states,
// the credit ceiling and the legal product type range.
package vm_pkg;

    localparam logic [1:0] CoinNone = 2'b00;
    localparam logic [1:0] Coin1    = 2'b01;
    localparam logic [1:0] Coin2    = 2'b10;
    localparam logic [1:0] Coin5    = 2'b11;

    localparam int unsigned CoinVal1 = 1;
    localparam int unsigned CoinVal2 = 2;
    localparam int unsigned CoinVal5 = 5;

    localparam int unsigned CREDIT_MAX = 15;

    localparam int unsigned TypeMin = 1;
    localparam int unsigned TypeMax = 5;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StRequest,
        StWait,
        StRefund
    } state_e;

    // Five bits wide so the credit sum can be range-checked before truncation.
    function automatic logic [4:0] coin_amount(input logic [1:0] code);
        logic [4:0] amount;
        case (code)
            Coin1:   amount = 5'(CoinVal1);
            Coin2:   amount = 5'(CoinVal2);
            Coin5:   amount = 5'(CoinVal5);
            default: amount = 5'd0;
        endcase
        return amount;
    endfunction

endpackage

// File: rtl/vm_timer.sv
// Clearable idle/response timer; tc is high while the count sits at TIMEOUT_CYCLES-1.
module vm_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == Last);

endmodule

// File: rtl/coin_collector.sv
// Vending front end: accumulates coin credit, issues one purchase request per buy,
// and refunds leftover credit on cancel, timeout or a partially spent purchase.
module coin_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CREDIT_MAX     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       cancel,
    input  logic       buy,
    input  logic [2:0] sel_type,
    input  logic [3:0] sel_number,
    output logic [3:0] money,
    output logic [2:0] index_type,
    output logic [3:0] in_number,
    output logic       req_valid,
    input  logic       rsp_valid,
    input  logic       rsp_error,
    input  logic [3:0] rsp_remaining,
    output logic [3:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       busy
);

    import vm_pkg::*;

    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [2:0] index_type_q;
    logic [3:0] in_number_q;
    logic [3:0] change_q;
    logic       req_valid_q, change_valid_q, coin_reject_q, busy_q;

    logic       accept, latch_sel, timer_clr, timer_en, timer_tc;
    logic       coin_fits, buy_legal, busy_d;
    logic [4:0] coin_sum;

    vm_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clr),
        .enable(timer_en),
        .tc    (timer_tc)
    );

    assign coin_sum  = {1'b0, credit_q} + coin_amount(coin_value);
    assign coin_fits = coin_valid && (coin_value != CoinNone) && (coin_sum <= 5'(CREDIT_MAX));
    assign buy_legal = buy && (sel_type >= 3'(TypeMin)) && (sel_type <= 3'(TypeMax))
                       && (sel_number != 4'd0);

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        accept    = 1'b0;
        latch_sel = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                credit_d  = '0;
                timer_clr = 1'b1;
                if (coin_fits) begin
                    accept   = 1'b1;
                    credit_d = coin_sum[3:0];
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                timer_en = 1'b1;
                // cancel beats buy beats coin; an illegal buy falls through untouched
                if (cancel) begin
                    state_d = StRefund;
                end else if (buy_legal) begin
                    latch_sel = 1'b1;
                    state_d   = StRequest;
                end else if (coin_fits) begin
                    accept    = 1'b1;
                    credit_d  = coin_sum[3:0];
                    timer_clr = 1'b1;
                end else if (timer_tc) begin
                    state_d = StRefund;
                end
            end
            StRequest: begin
                timer_clr = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                timer_en = 1'b1;
                if (rsp_valid) begin
                    if (rsp_error) begin
                        timer_clr = 1'b1;
                        state_d   = StCollect;
                    end else begin
                        credit_d = rsp_remaining;
                        state_d  = (rsp_remaining != 4'd0) ? StRefund : StIdle;
                    end
                end else if (timer_tc) begin
                    state_d = StRefund;
                end
            end
            StRefund: begin
                credit_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = (state_d == StRequest) || (state_d == StWait) || (state_d == StRefund);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            index_type_q   <= '0;
            in_number_q    <= '0;
            change_q       <= '0;
            req_valid_q    <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            req_valid_q    <= (state_d == StRequest);
            change_valid_q <= (state_d == StRefund);
            coin_reject_q  <= coin_valid && !accept;
            busy_q         <= busy_d;
            if (state_d == StRefund) begin
                change_q <= credit_d;
            end
            if (latch_sel) begin
                index_type_q <= sel_type;
                in_number_q  <= sel_number;
            end
        end
    end

    assign money        = credit_q;
    assign index_type   = index_type_q;
    assign in_number    = in_number_q;
    assign change       = change_q;
    assign req_valid    = req_valid_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: table of stimulus/expected records run through
// an in-order scoreboard, plus hand sequences for timeouts and reset mid-transaction.
module tb_coin_collector;

    localparam int unsigned T = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       buy;
    logic [2:0] sel_type;
    logic [3:0] sel_number;
    logic [3:0] money;
    logic [2:0] index_type;
    logic [3:0] in_number;
    logic       req_valid;
    logic       rsp_valid;
    logic       rsp_error;
    logic [3:0] rsp_remaining;
    logic [3:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    coin_collector #(
        .TIMEOUT_CYCLES(T),
        .CREDIT_MAX    (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .cancel       (cancel),
        .buy          (buy),
        .sel_type     (sel_type),
        .sel_number   (sel_number),
        .money        (money),
        .index_type   (index_type),
        .in_number    (in_number),
        .req_valid    (req_valid),
        .rsp_valid    (rsp_valid),
        .rsp_error    (rsp_error),
        .rsp_remaining(rsp_remaining),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cv, val, can, buy, st, sn, rv, re, rr;
        int m, rq, chv, chg, rej, bsy, it, inum;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input int cv, val, can, buy, st, sn, rv, re, rr,
                                input int m, rq, chv, chg, rej, bsy, it, inum);
        vec_t v;
        v.cv = cv; v.val = val; v.can = can; v.buy = buy; v.st = st; v.sn = sn;
        v.rv = rv; v.re = re; v.rr = rr;
        v.m = m; v.rq = rq; v.chv = chv; v.chg = chg; v.rej = rej; v.bsy = bsy;
        v.it = it; v.inum = inum;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        coin_valid = 0; coin_value = 0; cancel = 0; buy = 0; sel_type = 0; sel_number = 0;
        rsp_valid = 0; rsp_error = 0; rsp_remaining = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        coin_valid    = 1'(v.cv);
        coin_value    = 2'(v.val);
        cancel        = 1'(v.can);
        buy           = 1'(v.buy);
        sel_type      = 3'(v.st);
        sel_number    = 4'(v.sn);
        rsp_valid     = 1'(v.rv);
        rsp_error     = 1'(v.re);
        rsp_remaining = 4'(v.rr);
        exp_q.push_back(v);
        step();
        e = exp_q.pop_front();
        check({tag, " money"}, int'(money), e.m);
        check({tag, " req_valid"}, int'(req_valid), e.rq);
        check({tag, " change_valid"}, int'(change_valid), e.chv);
        if (e.chv != 0) check({tag, " change"}, int'(change), e.chg);
        check({tag, " coin_reject"}, int'(coin_reject), e.rej);
        check({tag, " busy"}, int'(busy), e.bsy);
        check({tag, " index_type"}, int'(index_type), e.it);
        check({tag, " in_number"}, int'(in_number), e.inum);
        drive_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " money"}, int'(money), 0);
        check({tag, " index_type"}, int'(index_type), 0);
        check({tag, " in_number"}, int'(in_number), 0);
        check({tag, " change"}, int'(change), 0);
        check({tag, " req_valid"}, int'(req_valid), 0);
        check({tag, " change_valid"}, int'(change_valid), 0);
        check({tag, " coin_reject"}, int'(coin_reject), 0);
        check({tag, " busy"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;

        // coin codes: 1 -> 1, 2 -> 2, 3 -> 5
        //               cv val can buy st sn rv re rr  money rq chv chg rej bsy it in
        // coins 5,5,2 -> 12, then 5 overflows and is rejected
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0,  12, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  12, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  12, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  12, 0, 1, 12, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, 0));
        // credit 10, buy type 3 qty 2, ok with 4 remaining -> change 4
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  10, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 2, 0, 0, 0,  10, 1, 0,  0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  10, 0, 0,  0, 0, 1, 3, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4,   4, 0, 1,  4, 0, 1, 3, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 3, 2));
        // stray response in IDLE ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7,   0, 0, 0,  0, 0, 0, 3, 2));
        // credit 6, buy refused -> back to COLLECT, cancel -> change 6
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 3, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0,  0, 0, 0, 3, 2));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0,   6, 1, 0,  0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0,  0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0,   6, 0, 0,  0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0,   6, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,   6, 0, 1,  6, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 1));
        // illegal buys and an invalid coin code are ignored / rejected
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 6, 1, 0, 0, 0,   2, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0,   2, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0,   2, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0,  0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 1,  2, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 1));
        // credit 7, cancel + buy + coin together -> refund 7, coin rejected, no request
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0,   7, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 4, 3, 0, 0, 0,   7, 0, 1,  7, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 1));
        // exactly CREDIT_MAX accepted, one more rejected, stray response ignored
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  10, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  15, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3,  15, 0, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  15, 0, 0,  0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  15, 0, 1, 15, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 1, 1));

        drive_idle();
        reset = 1'b1;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // credit 3 then silence: refund after T idle cycles in COLLECT
        apply(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1), "to1");
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1), "to2");
        seen = 0;
        k = 0;
        while (!seen && k < int'(T) + 5) begin
            step();
            k++;
            if (change_valid) seen = 1;
        end
        check("collect timeout latency", k, int'(T));
        check("collect timeout change", int'(change), 3);
        step();
        check("collect timeout idle money", int'(money), 0);
        check("collect timeout idle busy", int'(busy), 0);

        // no response: WAIT lasts T cycles, so refund appears T+1 cycles after REQUEST
        apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 1), "wt1");
        apply(mk(0, 0, 0, 1, 2, 5, 0, 0, 0, 5, 1, 0, 0, 0, 1, 2, 5), "wt2");
        seen = 0;
        k = 0;
        while (!seen && k < int'(T) + 6) begin
            step();
            k++;
            if (change_valid) seen = 1;
        end
        check("wait timeout latency", k, int'(T) + 1);
        check("wait timeout change", int'(change), 5);
        step();
        check("wait timeout idle money", int'(money), 0);

        // reset while in WAIT with credit 9 discards it silently
        apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 2, 5), "rw1");
        apply(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2, 5), "rw2");
        apply(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 2, 5), "rw3");
        apply(mk(0, 0, 0, 1, 4, 1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 4, 1), "rw4");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 4, 1), "rw5");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("reset in wait");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post reset change_valid %0d", i), int'(change_valid), 0);
            check($sformatf("post reset money %0d", i), int'(money), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
